reg_file: RTL and testbench

//  Architectural register file with per-register rename tags. Sits beside the decoder and

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_if.sv | 49 ++++
 rtl/reg_file_read_port.sv | 45 ++++
 rtl/reg_file.sv | 100 ++++++++++
 tb/tb_reg_file.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared sizing and types for the architectural register file, also used by ROB and decoder.
package reg_file_pkg;

    localparam int unsigned REG_NUM    = 32;
    localparam int unsigned REG_ID_WID = $clog2(REG_NUM);
    localparam int unsigned ROB_ID_WID = 4;
    localparam int unsigned DATA_WID   = 32;

    // Rename state of a single architectural register
    typedef enum logic {
        REG_FREE = 1'b0,
        REG_BUSY = 1'b1
    } reg_state_e;

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// Decoder/ROB-facing bus of the register file: issue, commit, rollback and two read ports.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_WID,
    parameter int unsigned ROB_ID_W = ROB_ID_WID,
    parameter int unsigned REG_ID_W = REG_ID_WID
);
    logic                rdy;
    logic                rollback;

    logic                issue_valid;
    logic [REG_ID_W-1:0] issue_rd;
    logic [ROB_ID_W-1:0] issue_rob_id;

    logic                commit_valid;
    logic [REG_ID_W-1:0] commit_rd;
    logic [DATA_W-1:0]   commit_data;
    logic [ROB_ID_W-1:0] commit_rob_id;

    logic [REG_ID_W-1:0] rs1_id;
    logic                rs1_busy;
    logic [ROB_ID_W-1:0] rs1_rob_id;
    logic [DATA_W-1:0]   rs1_data;

    logic [REG_ID_W-1:0] rs2_id;
    logic                rs2_busy;
    logic [ROB_ID_W-1:0] rs2_rob_id;
    logic [DATA_W-1:0]   rs2_data;

    modport master (
        output rdy, rollback,
        output issue_valid, issue_rd, issue_rob_id,
        output commit_valid, commit_rd, commit_data, commit_rob_id,
        output rs1_id, rs2_id,
        input  rs1_busy, rs1_rob_id, rs1_data,
        input  rs2_busy, rs2_rob_id, rs2_data
    );

    modport slave (
        input  rdy, rollback,
        input  issue_valid, issue_rd, issue_rob_id,
        input  commit_valid, commit_rd, commit_data, commit_rob_id,
        input  rs1_id, rs2_id,
        output rs1_busy, rs1_rob_id, rs1_data,
        output rs2_busy, rs2_rob_id, rs2_data
    );

endinterface : reg_file_if

// File: rtl/reg_file_read_port.sv
// One combinational operand lookup with forwarding of a matching same-cycle commit.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_NUM_P = REG_NUM,
    parameter int unsigned DATA_W    = DATA_WID,
    parameter int unsigned ROB_ID_W  = ROB_ID_WID,
    parameter int unsigned REG_ID_W  = REG_ID_WID
) (
    input  logic [REG_ID_W-1:0] i_rs_id,
    input  logic [DATA_W-1:0]   i_data [REG_NUM_P],
    input  logic [REG_NUM_P-1:0] i_busy,
    input  logic [ROB_ID_W-1:0] i_tag  [REG_NUM_P],
    input  logic                i_commit_valid,
    input  logic [REG_ID_W-1:0] i_commit_rd,
    input  logic [DATA_W-1:0]   i_commit_data,
    input  logic [ROB_ID_W-1:0] i_commit_rob_id,
    output logic                o_busy,
    output logic [ROB_ID_W-1:0] o_rob_id,
    output logic [DATA_W-1:0]   o_data
);

    logic w_fwd;

    // Only the commit of the current producer may bypass; a stale commit is ignored.
    assign w_fwd = i_commit_valid && (i_commit_rd == i_rs_id) && i_busy[i_rs_id]
                   && (i_tag[i_rs_id] == i_commit_rob_id);

    always_comb begin
        o_busy   = 1'b0;
        o_rob_id = '0;
        o_data   = '0;
        if (i_rs_id != '0) begin
            o_rob_id = i_tag[i_rs_id];
            if (w_fwd) begin
                o_busy = 1'b0;
                o_data = i_commit_data;
            end else begin
                o_busy = i_busy[i_rs_id];
                o_data = i_data[i_rs_id];
            end
        end
    end

endmodule : rf_read_port

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags; x0 reads as zero.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_NUM_P = REG_NUM,
    parameter int unsigned DATA_W    = DATA_WID,
    parameter int unsigned ROB_ID_W  = ROB_ID_WID
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);

    localparam int unsigned REG_ID_W = $clog2(REG_NUM_P);

    logic [DATA_W-1:0]    w_data [REG_NUM_P];
    logic [ROB_ID_W-1:0]  w_tag  [REG_NUM_P];
    logic [REG_NUM_P-1:0] w_busy;

    assign w_data[0] = '0;
    assign w_tag[0]  = '0;
    assign w_busy[0] = 1'b0;

    for (genvar i = 1; i < REG_NUM_P; i++) begin : g_reg
        localparam logic [REG_ID_W-1:0] IDX = REG_ID_W'(i);

        reg_state_e          r_state;
        logic [DATA_W-1:0]   r_data;
        logic [ROB_ID_W-1:0] r_tag;
        logic                w_commit_hit;
        logic                w_issue_hit;

        assign w_commit_hit = bus.commit_valid && (bus.commit_rd == IDX);
        assign w_issue_hit  = bus.issue_valid && (bus.issue_rd == IDX);

        // Commit data is written even on rollback: the committing op is older than the flush.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= REG_FREE;
                r_data  <= '0;
                r_tag   <= '0;
            end else if (bus.rdy) begin
                if (w_commit_hit) begin
                    r_data <= bus.commit_data;
                end
                if (bus.rollback) begin
                    r_state <= REG_FREE;
                end else if (w_issue_hit) begin
                    r_state <= REG_BUSY;
                    r_tag   <= bus.issue_rob_id;
                end else if (w_commit_hit && (r_tag == bus.commit_rob_id)) begin
                    r_state <= REG_FREE;
                end
            end
        end

        assign w_data[i] = r_data;
        assign w_tag[i]  = r_tag;
        assign w_busy[i] = (r_state == REG_BUSY);
    end

    rf_read_port #(
        .REG_NUM_P (REG_NUM_P),
        .DATA_W    (DATA_W),
        .ROB_ID_W  (ROB_ID_W),
        .REG_ID_W  (REG_ID_W)
    ) u_rs1 (
        .i_rs_id         (bus.rs1_id),
        .i_data          (w_data),
        .i_busy          (w_busy),
        .i_tag           (w_tag),
        .i_commit_valid  (bus.commit_valid),
        .i_commit_rd     (bus.commit_rd),
        .i_commit_data   (bus.commit_data),
        .i_commit_rob_id (bus.commit_rob_id),
        .o_busy          (bus.rs1_busy),
        .o_rob_id        (bus.rs1_rob_id),
        .o_data          (bus.rs1_data)
    );

    rf_read_port #(
        .REG_NUM_P (REG_NUM_P),
        .DATA_W    (DATA_W),
        .ROB_ID_W  (ROB_ID_W),
        .REG_ID_W  (REG_ID_W)
    ) u_rs2 (
        .i_rs_id         (bus.rs2_id),
        .i_data          (w_data),
        .i_busy          (w_busy),
        .i_tag           (w_tag),
        .i_commit_valid  (bus.commit_valid),
        .i_commit_rd     (bus.commit_rd),
        .i_commit_data   (bus.commit_data),
        .i_commit_rob_id (bus.commit_rob_id),
        .o_busy          (bus.rs2_busy),
        .o_rob_id        (bus.rs2_rob_id),
        .o_data          (bus.rs2_data)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expected read results are queued with the stimulus.
module tb_reg_file;
    import reg_file_pkg::*;

    typedef struct {
        string       nm;
        logic        busy;
        logic [3:0]  rob;
        logic [31:0] data;
        bit          chk_rob;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    reg_file_if #(.DATA_W(32), .ROB_ID_W(4), .REG_ID_W(5)) bus ();

    reg_file #(.REG_NUM_P(32), .DATA_W(32), .ROB_ID_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string nm, input logic b, input logic [3:0] r,
                             input logic [31:0] d, input bit cr);
        exp_t e;
        e.nm = nm; e.busy = b; e.rob = r; e.data = d; e.chk_rob = cr;
        exp_q.push_back(e);
    endtask

    task automatic cmp_port(input logic b, input logic [3:0] r, input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.nm, ".busy"}, 32'(b), 32'(e.busy));
            check_eq({e.nm, ".data"}, d, e.data);
            if (e.chk_rob) check_eq({e.nm, ".rob"}, 32'(r), 32'(e.rob));
        end
    endtask

    task automatic probe(input logic [4:0] a, input logic [4:0] b);
        bus.rs1_id = a;
        bus.rs2_id = b;
        #1;
        cmp_port(bus.rs1_busy, bus.rs1_rob_id, bus.rs1_data);
        cmp_port(bus.rs2_busy, bus.rs2_rob_id, bus.rs2_data);
    endtask

    task automatic idle();
        bus.rollback = 1'b0; bus.issue_valid = 1'b0; bus.commit_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] rob);
        bus.issue_valid = 1'b1; bus.issue_rd = rd; bus.issue_rob_id = rob;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] rob, input logic [31:0] d);
        bus.commit_valid = 1'b1; bus.commit_rd = rd; bus.commit_rob_id = rob; bus.commit_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.issue_rd = '0; bus.issue_rob_id = '0;
        bus.commit_rd = '0; bus.commit_rob_id = '0; bus.commit_data = '0;
        bus.rs1_id = '0; bus.rs2_id = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // 1: reset state on both ports
        for (int unsigned i = 0; i < 32; i++) begin
            expect_rd($sformatf("rst_x%0d", i), 1'b0, 4'd0, 32'd0, 1'b1);
            expect_rd($sformatf("rst_x%0d", 31 - i), 1'b0, 4'd0, 32'd0, 1'b1);
            probe(5'(i), 5'(31 - i));
        end

        // 2: issue, forward on commit, then state
        issue(5'd5, 4'd3);
        tick(); idle();
        expect_rd("t2_busy", 1'b1, 4'd3, 32'd0, 1'b1);
        expect_rd("t2_x0", 1'b0, 4'd0, 32'd0, 1'b1);
        probe(5'd5, 5'd0);
        commit(5'd5, 4'd3, 32'hDEAD);
        expect_rd("t2_fwd1", 1'b0, 4'd0, 32'hDEAD, 1'b0);
        expect_rd("t2_fwd2", 1'b0, 4'd0, 32'hDEAD, 1'b0);
        probe(5'd5, 5'd5);
        tick(); idle();
        expect_rd("t2_state", 1'b0, 4'd0, 32'hDEAD, 1'b0);
        expect_rd("t2_x0b", 1'b0, 4'd0, 32'd0, 1'b1);
        probe(5'd5, 5'd0);
        commit(5'd5, 4'd3, 32'h77);
        expect_rd("t2_nofwd_free", 1'b0, 4'd0, 32'hDEAD, 1'b0);
        expect_rd("t2_nofwd_free2", 1'b0, 4'd0, 32'hDEAD, 1'b0);
        probe(5'd5, 5'd5);
        tick(); idle();
        expect_rd("t2_late", 1'b0, 4'd0, 32'h77, 1'b0);
        expect_rd("t2_late2", 1'b0, 4'd0, 32'h77, 1'b0);
        probe(5'd5, 5'd5);

        // 3: stale commit keeps younger tag
        issue(5'd7, 4'd2); tick();
        issue(5'd7, 4'd9); tick(); idle();
        commit(5'd7, 4'd2, 32'h11);
        expect_rd("t3_nofwd", 1'b1, 4'd9, 32'd0, 1'b1);
        expect_rd("t3_nofwd2", 1'b1, 4'd9, 32'd0, 1'b1);
        probe(5'd7, 5'd7);
        tick(); idle();
        expect_rd("t3_after", 1'b1, 4'd9, 32'h11, 1'b1);
        expect_rd("t3_x5", 1'b0, 4'd0, 32'h77, 1'b0);
        probe(5'd7, 5'd5);

        // 4: same-cycle issue and commit to x4
        issue(5'd4, 4'd1); tick();
        issue(5'd4, 4'd6);
        commit(5'd4, 4'd1, 32'h22);
        expect_rd("t4_fwd", 1'b0, 4'd0, 32'h22, 1'b0);
        expect_rd("t4_x7", 1'b1, 4'd9, 32'h11, 1'b1);
        probe(5'd4, 5'd7);
        tick(); idle();
        expect_rd("t4_after", 1'b1, 4'd6, 32'h22, 1'b1);
        expect_rd("t4_x0", 1'b0, 4'd0, 32'd0, 1'b1);
        probe(5'd4, 5'd0);

        // 5: rollback with same-cycle commit and issue
        issue(5'd1, 4'd10); tick();
        issue(5'd2, 4'd11); tick();
        issue(5'd3, 4'd12); tick(); idle();
        expect_rd("t5_x1", 1'b1, 4'd10, 32'd0, 1'b1);
        expect_rd("t5_x2", 1'b1, 4'd11, 32'd0, 1'b1);
        probe(5'd1, 5'd2);
        bus.rollback = 1'b1;
        commit(5'd2, 4'd11, 32'h33);
        issue(5'd8, 4'd7);
        expect_rd("t5_x2fwd", 1'b0, 4'd0, 32'h33, 1'b0);
        expect_rd("t5_x3pre", 1'b1, 4'd12, 32'd0, 1'b1);
        probe(5'd2, 5'd3);
        tick(); idle();
        expect_rd("t5_x1rb", 1'b0, 4'd0, 32'd0, 1'b0);
        expect_rd("t5_x2rb", 1'b0, 4'd0, 32'h33, 1'b0);
        probe(5'd1, 5'd2);
        expect_rd("t5_x3rb", 1'b0, 4'd0, 32'd0, 1'b0);
        expect_rd("t5_x8rb", 1'b0, 4'd0, 32'd0, 1'b0);
        probe(5'd3, 5'd8);
        expect_rd("t5_x7rb", 1'b0, 4'd0, 32'h11, 1'b0);
        expect_rd("t5_x4rb", 1'b0, 4'd0, 32'h22, 1'b0);
        probe(5'd7, 5'd4);

        // 6: x0 writes dropped, rdy=0 freezes state
        issue(5'd0, 4'd5);
        commit(5'd0, 4'd0, 32'hFF);
        expect_rd("t6_x0fwd", 1'b0, 4'd0, 32'd0, 1'b1);
        expect_rd("t6_x0fwd2", 1'b0, 4'd0, 32'd0, 1'b1);
        probe(5'd0, 5'd0);
        tick(); idle();
        expect_rd("t6_x0", 1'b0, 4'd0, 32'd0, 1'b1);
        expect_rd("t6_x0b", 1'b0, 4'd0, 32'd0, 1'b1);
        probe(5'd0, 5'd0);
        bus.rdy = 1'b0;
        issue(5'd9, 4'd4);
        commit(5'd9, 4'd0, 32'hAB);
        expect_rd("t6_x9live", 1'b0, 4'd0, 32'd0, 1'b0);
        expect_rd("t6_x2live", 1'b0, 4'd0, 32'h33, 1'b0);
        probe(5'd9, 5'd2);
        tick(); idle();
        bus.rdy = 1'b1;
        expect_rd("t6_x9", 1'b0, 4'd0, 32'd0, 1'b0);
        expect_rd("t6_x2", 1'b0, 4'd0, 32'h33, 1'b0);
        probe(5'd9, 5'd2);
        issue(5'd10, 4'd13); tick(); idle();
        bus.rdy = 1'b0;
        bus.rollback = 1'b1;
        tick(); idle();
        bus.rdy = 1'b1;
        expect_rd("t6_x10frz", 1'b1, 4'd13, 32'd0, 1'b1);
        expect_rd("t6_x0c", 1'b0, 4'd0, 32'd0, 1'b1);
        probe(5'd10, 5'd0);

        // reset clears data and busy
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_rd("rst2_x10", 1'b0, 4'd0, 32'd0, 1'b1);
        expect_rd("rst2_x2", 1'b0, 4'd0, 32'd0, 1'b1);
        probe(5'd10, 5'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file
